digi_ota_sample_ctrl: RTL and testbench
=======================================

// Module: digi_ota_sample_ctrl
// PURPOSE
//   Sequencer for the gate-level digital OTA/comparator on the analog pins.
//   Enables the OTA, waits a settling window, then synchronises its async output.
//   Takes NUM_SAMPLES samples and majority-votes them into one registered decision.
//   Sits between the TT digital pins (start/abort/mode) and the OTA enable/output nets.
// PARAMETERS
//   SETTLE_CYCLES  4  cycles ota_en is high before sampling starts (>=1)
//   NUM_SAMPLES    8  synchronised samples per conversion (>=1)
//   CNT_W          $clog2(NUM_SAMPLES+1)  derived localparam, width of ones_cnt
// PORTS
//   clk        in   1      system clock
//   rst_n      in   1      asynchronous, active-low reset
//   start      in   1      level; sampled in IDLE only, begins a conversion
//   abort      in   1      level; returns to IDLE from any state, priority over start
//   cont       in   1      continuous mode; sampled in DONE
//   cmp_in     in   1      raw asynchronous OTA output
//   ota_en     out  1      OTA enable, registered
//   busy       out  1      high in any state other than IDLE
//   valid      out  1      one-cycle pulse when result/ones_cnt update
//   result     out  1      majority decision of the last conversion
//   ones_cnt   out  CNT_W  number of samples that were 1 in the last conversion
//   conv_cnt   out  8      completed conversions, wraps 255->0
// BEHAVIOUR
//   Reset (async assert, sync release):
//     - state=IDLE; every output and internal register is 0, including both sync flops.
//   Synchroniser:
//     - Two-flop chain on cmp_in, free-running in all states.
//     - cmp_s lags cmp_in by 2 edges; SETTLE_CYCLES covers this.
//   FSM states: IDLE, SETTLE, SAMPLE, DONE. All outputs are registered.
//   IDLE:
//     - ota_en=0, busy=0.
//     - start=1 & abort=0 at an edge -> SETTLE; settle_ctr=0, acc=0.
//   SETTLE:
//     - ota_en=1, busy=1; increments settle_ctr each cycle.
//     - After exactly SETTLE_CYCLES cycles -> SAMPLE.
//   SAMPLE:
//     - acc += cmp_s each cycle, for exactly NUM_SAMPLES cycles -> DONE.
//     - acc never overflows: its width is CNT_W.
//   DONE (lasts 1 cycle):
//     - valid=1, ones_cnt=acc, result=(2*acc > NUM_SAMPLES).
//     - A tie gives result=0 (strict majority).
//     - conv_cnt increments modulo 256.
//     - Next state: cont=1 -> SAMPLE with acc=0 and ota_en held high (no re-settle).
//     - Next state: cont=0 -> IDLE with ota_en=0.
//   Latency: start sampled at edge 0 -> ota_en high after edge 1.
//     valid is high for the cycle following edge 1+SETTLE_CYCLES+NUM_SAMPLES.
//   Continuous mode: valid repeats every NUM_SAMPLES+1 cycles.
//   start while busy: ignored, no queueing.
//   abort=1 in any state:
//     - Next state is IDLE, ota_en=0, busy=0.
//     - valid is not asserted; acc is discarded.
//     - result, ones_cnt and conv_cnt keep their previous values.
//   abort and start both high in IDLE: stays IDLE.
//   abort in DONE: valid for that cycle already fired; the next state is still IDLE.
//   result, ones_cnt and conv_cnt change only in DONE; they hold otherwise.
//   rst_n low mid-conversion: immediate return to reset values; no valid.
// TESTING
//   1. Reset then idle: all outputs 0; cmp_in toggling alone never raises busy or valid.
//   2. Defaults, cmp_in=1, start pulse at edge 0:
//      ota_en rises after edge 1; valid after edge 13; result=1, ones_cnt=8, conv_cnt=1.
//   3. cmp_in high for exactly 4 of 8 samples -> ones_cnt=4, result=0 (tie).
//      cmp_in high for 5 of 8 samples -> ones_cnt=5, result=1.
//   4. cont=1, cmp_in=0: valid every 9 cycles and ota_en never drops.
//      Run 256 conversions: conv_cnt wraps to 0.
//   5. abort in SAMPLE mid-conversion: IDLE next cycle, ota_en=0, no valid.
//      Previous result and ones_cnt are retained.
//   6. start held high through a conversion with cont=0:
//      returns to IDLE, then restarts on the next edge; re-pulsing start while busy has no effect.

Source files
------------

// File: rtl/digi_ota_sample_ctrl.sv
// Sequencer for the digital OTA/comparator: enables it, waits a settling window,
// then majority-votes NUM_SAMPLES synchronised samples into one registered decision.
module digi_ota_sample_ctrl #(
  parameter int SETTLE_CYCLES = 4,
  parameter int NUM_SAMPLES   = 8,
  localparam int CNT_W        = $clog2(NUM_SAMPLES + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic             cont,
  input  logic             cmp_in,
  output logic             ota_en,
  output logic             busy,
  output logic             valid,
  output logic             result,
  output logic [CNT_W-1:0] ones_cnt,
  output logic [7:0]       conv_cnt
);

  localparam int SET_W = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
  localparam int SMP_W = (NUM_SAMPLES > 1) ? $clog2(NUM_SAMPLES) : 1;
  localparam logic [SET_W-1:0] SETTLE_LAST = SET_W'(SETTLE_CYCLES - 1);
  localparam logic [SMP_W-1:0] SAMPLE_LAST = SMP_W'(NUM_SAMPLES - 1);
  localparam logic [CNT_W:0]   HALF_THRESH = (CNT_W + 1)'(NUM_SAMPLES);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  state_t state, next_state;

  logic             sync1, cmp_s;
  logic [SET_W-1:0] settle_ctr;
  logic [SMP_W-1:0] smp_ctr;
  logic [CNT_W-1:0] acc;
  logic [CNT_W:0]   acc_x2;

  // Two-flop synchroniser on the asynchronous comparator output, always running.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      cmp_s <= 1'b0;
    end else begin
      sync1 <= cmp_in;
      cmp_s <= sync1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  // NOTE: next_state gets a default before the case so no path can infer a latch.
  always_comb begin
    next_state = state;
    unique case (state)
      IDLE:    if (start) next_state = SETTLE;
      SETTLE:  if (settle_ctr == SETTLE_LAST) next_state = SAMPLE;
      SAMPLE:  if (smp_ctr == SAMPLE_LAST) next_state = DONE;
      DONE:    next_state = cont ? SAMPLE : IDLE;
      default: next_state = IDLE;
    endcase
    if (abort) next_state = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      settle_ctr <= '0;
      smp_ctr    <= '0;
      acc        <= '0;
    end else begin
      unique case (state)
        SETTLE: begin
          settle_ctr <= settle_ctr + SET_W'(1);
          smp_ctr    <= '0;
          acc        <= '0;
        end
        SAMPLE: begin
          smp_ctr <= smp_ctr + SMP_W'(1);
          acc     <= acc + CNT_W'(cmp_s);
        end
        default: begin
          settle_ctr <= '0;
          smp_ctr    <= '0;
          acc        <= '0;
        end
      endcase
    end
  end

  assign acc_x2 = {acc, 1'b0};

  // Results publish on the edge leaving DONE, so an abort seen in DONE cannot cancel them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ota_en   <= 1'b0;
      busy     <= 1'b0;
      valid    <= 1'b0;
      result   <= 1'b0;
      ones_cnt <= '0;
      conv_cnt <= '0;
    end else begin
      ota_en <= (state != IDLE) && (next_state != IDLE);
      busy   <= (next_state != IDLE);
      valid  <= (state == DONE);
      if (state == DONE) begin
        ones_cnt <= acc;
        result   <= (acc_x2 > HALF_THRESH);
        conv_cnt <= conv_cnt + 8'd1;
      end
    end
  end

endmodule

// File: tb/tb_digi_ota_sample_ctrl.sv
// Scoreboard bench for digi_ota_sample_ctrl: stimulus pushes expected results,
// a negedge monitor pops one entry for every valid pulse.
module tb_digi_ota_sample_ctrl;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       start = 1'b0;
  logic       abort = 1'b0;
  logic       cont = 1'b0;
  logic       cmp_in = 1'b0;
  logic       ota_en, busy, valid, result;
  logic [3:0] ones_cnt;
  logic [7:0] conv_cnt;

  typedef struct packed {
    logic       result;
    logic [3:0] ones;
    logic [7:0] conv;
  } exp_t;

  exp_t       sb_q[$];
  int         n_cmp = 0;
  int         n_err = 0;
  logic [7:0] exp_conv = 8'd0;

  digi_ota_sample_ctrl dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .cont(cont),
    .cmp_in(cmp_in), .ota_en(ota_en), .busy(busy), .valid(valid),
    .result(result), .ones_cnt(ones_cnt), .conv_cnt(conv_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: every valid pulse must match the oldest expected entry.
  always @(negedge clk) begin
    if (rst_n && valid) begin
      if (sb_q.size() == 0) begin
        check("unexpected_valid", 32'd1, 32'd0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        check("sb_result", {31'd0, result}, {31'd0, e.result});
        check("sb_ones_cnt", {28'd0, ones_cnt}, {28'd0, e.ones});
        check("sb_conv_cnt", {24'd0, conv_cnt}, {24'd0, e.conv});
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push_expected(input logic [3:0] ones);
    exp_t e;
    exp_conv   = exp_conv + 8'd1;
    e.result   = (2 * ones) > 8;
    e.ones     = ones;
    e.conv     = exp_conv;
    sb_q.push_back(e);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    start = 1'b0; abort = 1'b0; cont = 1'b0; cmp_in = 1'b0;
    #12;
    sb_q.delete();
    exp_conv = 8'd0;
    rst_n = 1'b1;
    tick();
  endtask

  // One conversion with cont=0. Samples at edges 5..12 see cmp_in driven before edges 3..10.
  task automatic conversion(input logic [7:0] pat, input string tag);
    push_expected(4'($countones(pat)));
    start  = 1'b1;
    cmp_in = 1'b0;
    for (int e = 0; e <= 13; e++) begin
      tick();
      if (e == 0) begin
        start = 1'b0;
        check({tag, "_busy_e0"}, {31'd0, busy}, 32'd1);
        check({tag, "_ota_en_e0"}, {31'd0, ota_en}, 32'd0);
      end
      if (e == 1)  check({tag, "_ota_en_e1"}, {31'd0, ota_en}, 32'd1);
      if (e == 12) check({tag, "_valid_e12"}, {31'd0, valid}, 32'd0);
      if (e == 13) begin
        check({tag, "_valid_e13"}, {31'd0, valid}, 32'd1);
        check({tag, "_busy_e13"}, {31'd0, busy}, 32'd0);
        check({tag, "_ota_en_e13"}, {31'd0, ota_en}, 32'd0);
      end
      cmp_in = (e + 1 >= 3 && e + 1 <= 10) ? pat[e - 2] : 1'b0;
    end
    tick();
  endtask

  initial begin
    int nv, drops, bad_gap, last_v;

    // 1. Reset and idle with cmp_in toggling.
    #2;
    check("rst_busy", {31'd0, busy}, 32'd0);
    check("rst_ota_en", {31'd0, ota_en}, 32'd0);
    check("rst_valid", {31'd0, valid}, 32'd0);
    check("rst_result", {31'd0, result}, 32'd0);
    check("rst_ones_cnt", {28'd0, ones_cnt}, 32'd0);
    check("rst_conv_cnt", {24'd0, conv_cnt}, 32'd0);
    do_reset();
    nv = 0;
    for (int i = 0; i < 20; i++) begin
      cmp_in = ~cmp_in;
      tick();
      if (busy || valid || ota_en) nv++;
    end
    check("idle_toggle_quiet", nv, 0);
    cmp_in = 1'b0;

    // 2./3. Directed conversions: all ones, tie, 5 of 8, all zeros.
    conversion(8'hFF, "all_ones");
    conversion(8'hAA, "tie_4of8");
    conversion(8'b1110_1100, "five_of8");
    conversion(8'h00, "all_zero");

    // abort and start together in IDLE: stays IDLE.
    start = 1'b1; abort = 1'b1;
    tick(); tick(); tick();
    check("start_abort_idle", {31'd0, busy}, 32'd0);
    start = 1'b0; abort = 1'b0;

    // 5. abort mid-SAMPLE keeps previous results.
    conversion(8'hFF, "pre_abort");
    start = 1'b1; cmp_in = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      start = 1'b0;
    end
    abort = 1'b1;
    tick();
    abort = 1'b0;
    check("abort_busy", {31'd0, busy}, 32'd0);
    check("abort_ota_en", {31'd0, ota_en}, 32'd0);
    check("abort_result", {31'd0, result}, 32'd1);
    check("abort_ones_cnt", {28'd0, ones_cnt}, 32'd8);
    check("abort_conv_cnt", {24'd0, conv_cnt}, {24'd0, exp_conv});
    for (int i = 0; i < 20; i++) tick();
    cmp_in = 1'b0;

    // 6. start held high: back to IDLE for one cycle, then restarts; re-pulse ignored.
    push_expected(4'd8);
    push_expected(4'd8);
    cmp_in = 1'b1;
    start  = 1'b1;
    for (int e = 0; e <= 27; e++) begin
      tick();
      if (e == 13) begin
        check("hold_valid1", {31'd0, valid}, 32'd1);
        check("hold_idle_gap", {31'd0, busy}, 32'd0);
      end
      if (e == 14) begin
        check("hold_restart_busy", {31'd0, busy}, 32'd1);
        start = 1'b0;
      end
      if (e == 18) start = 1'b1;
      if (e == 19) start = 1'b0;
      if (e == 26) check("hold_valid2_early", {31'd0, valid}, 32'd0);
      if (e == 27) check("hold_valid2", {31'd0, valid}, 32'd1);
    end
    for (int i = 0; i < 10; i++) tick();
    check("hold_no_extra", {31'd0, busy}, 32'd0);
    cmp_in = 1'b0;

    // Async reset mid-conversion: immediate return to zeros, no valid.
    start = 1'b1;
    for (int e = 0; e < 8; e++) begin
      tick();
      start = 1'b0;
    end
    rst_n = 1'b0;
    #1;
    check("rst_mid_busy", {31'd0, busy}, 32'd0);
    check("rst_mid_ota_en", {31'd0, ota_en}, 32'd0);
    check("rst_mid_conv_cnt", {24'd0, conv_cnt}, 32'd0);
    do_reset();

    // 4. Continuous mode: 256 conversions, period 9, ota_en never drops, conv_cnt wraps.
    for (int i = 0; i < 256; i++) push_expected(4'd0);
    cont = 1'b1; start = 1'b1;
    tick();
    start = 1'b0;
    nv = 0; drops = 0; bad_gap = 0; last_v = 0;
    for (int c = 1; c < 3000 && nv < 256; c++) begin
      tick();
      if (!ota_en) drops++;
      if (valid) begin
        if (nv == 0 && c != 13) bad_gap++;
        if (nv > 0 && c - last_v != 9) bad_gap++;
        nv++;
        last_v = c;
      end
    end
    check("cont_valid_count", nv, 256);
    check("cont_ota_drops", drops, 0);
    check("cont_bad_gaps", bad_gap, 0);
    check("cont_wrap_conv_cnt", {24'd0, conv_cnt}, 32'd0);
    abort = 1'b1;
    tick();
    abort = 1'b0; cont = 1'b0;
    check("cont_abort_busy", {31'd0, busy}, 32'd0);
    check("cont_abort_ota_en", {31'd0, ota_en}, 32'd0);
    for (int i = 0; i < 15; i++) tick();

    check("sb_drained", sb_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
